edac_err_logger: RTL and testbench

EDAC_ERR_LOGGER -- requirements
Module: edac_err_logger

---
 rtl/edac_errlog_pkg.sv | 29 ++
 rtl/edac_err_logger_if.sv | 31 +++
 rtl/edac_errlog_fifo.sv | 84 ++++++++
 rtl/edac_err_logger.sv | 127 ++++++++++++
 tb/tb_edac_err_logger.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edac_errlog_pkg.sv
// Shared types and sizing for the EDAC error logger.
// EDAC_ERRLOG_FIFO_EN selects a 4-entry log FIFO; otherwise the log is one holding register.
package edac_errlog_pkg;

`ifdef EDAC_ERRLOG_FIFO_EN
  localparam int unsigned LOG_DEPTH = 4;
`else
  localparam int unsigned LOG_DEPTH = 1;
`endif

  localparam int unsigned LOG_PTR_W      = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned LOG_CNT_W      = $clog2(LOG_DEPTH + 1);
  // Widest address an entry can carry; narrower ADDR_WIDTH values are zero-extended.
  localparam int unsigned LOG_ADDR_MAX_W = 32;

  typedef struct packed {
    logic [LOG_ADDR_MAX_W-1:0] addr;
    logic                      ue;
    logic                      scrub;
  } log_entry_t;

  function automatic logic [LOG_PTR_W-1:0] ptr_inc(input logic [LOG_PTR_W-1:0] p);
    if (p == LOG_PTR_W'(LOG_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/edac_err_logger_if.sv
// Event, control and status bundle between the EDAC/consumer side (master) and the logger (slave).
interface edac_err_logger_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  ERROR;
  logic                  CORRECTABLE;
  logic                  NOW_SCRUBBING;
  logic [ADDR_WIDTH-1:0] RAM_RA_LAT;
  logic                  CNT_CLR;
  logic                  LOG_POP;
  logic                  IRQ_CLR;
  logic [CNT_WIDTH-1:0]  CE_CNT;
  logic [CNT_WIDTH-1:0]  UE_CNT;
  logic                  LOG_VALID;
  logic [ADDR_WIDTH-1:0] LOG_ADDR;
  logic                  LOG_UE;
  logic                  LOG_SCRUB;
  logic                  OVERFLOW;
  logic                  IRQ;

  modport master (
    output ERROR, CORRECTABLE, NOW_SCRUBBING, RAM_RA_LAT, CNT_CLR, LOG_POP, IRQ_CLR,
    input  CE_CNT, UE_CNT, LOG_VALID, LOG_ADDR, LOG_UE, LOG_SCRUB, OVERFLOW, IRQ
  );

  modport slave (
    input  ERROR, CORRECTABLE, NOW_SCRUBBING, RAM_RA_LAT, CNT_CLR, LOG_POP, IRQ_CLR,
    output CE_CNT, UE_CNT, LOG_VALID, LOG_ADDR, LOG_UE, LOG_SCRUB, OVERFLOW, IRQ
  );
endinterface

// File: rtl/edac_errlog_fifo.sv
// Error log storage: owns push, pop, full/empty and occupancy. Depth comes from the package;
// a full log accepts a push only when a valid pop frees a slot in the same cycle.
module edac_errlog_fifo
  import edac_errlog_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  log_entry_t i_entry,
  input  logic       i_pop,
  output log_entry_t o_head,
  output logic       o_empty,
  output logic       o_drop
);

  logic [LOG_CNT_W-1:0] r_count;
  logic                 w_full;
  logic                 w_pop_ok;
  logic                 w_push_ok;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == LOG_CNT_W'(LOG_DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign o_drop    = i_push & ~w_push_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop_ok && !w_push_ok) begin
      r_count <= r_count - 1'b1;
    end
  end

  generate
    if (LOG_DEPTH == 1) begin : g_hold
      log_entry_t r_hold;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_hold <= '0;
        end else if (i_clr) begin
          r_hold <= '0;
        end else if (w_push_ok) begin
          r_hold <= i_entry;
        end
      end

      assign o_head = r_hold;
    end else begin : g_ring
      log_entry_t           r_mem [LOG_DEPTH];
      logic [LOG_PTR_W-1:0] r_wr_ptr;
      logic [LOG_PTR_W-1:0] r_rd_ptr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < LOG_DEPTH; i++) r_mem[i] <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else if (i_clr) begin
          for (int unsigned i = 0; i < LOG_DEPTH; i++) r_mem[i] <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
          end
          if (w_pop_ok) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
          end
        end
      end

      assign o_head = r_mem[r_rd_ptr];
    end
  endgenerate

endmodule

// File: rtl/edac_err_logger.sv
// EDAC error logger top: registers decoder flags, keeps saturating CE/UE counters, a sticky
// overflow flag and a level IRQ, and logs every event into edac_errlog_fifo.
module edac_err_logger
  import edac_errlog_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic               RCLK,
  input  logic               NGRST,
  input  logic               RST,
  edac_err_logger_if.slave   bus
);

  logic                  r_err;
  logic                  r_ce;
  logic                  r_scrub;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_ce_cnt;
  logic [CNT_WIDTH-1:0]  r_ue_cnt;
  logic                  r_ovf;
  logic                  r_irq;

  logic                  w_ce_ev;
  logic                  w_ue_ev;
  logic [CNT_WIDTH-1:0]  w_ce_cnt_d;
  logic [CNT_WIDTH-1:0]  w_ue_cnt_d;
  log_entry_t            w_entry;
  log_entry_t            w_head;
  logic                  w_empty;
  logic                  w_drop;

  always_ff @(posedge RCLK or negedge NGRST) begin
    if (!NGRST) begin
      r_err   <= 1'b0;
      r_ce    <= 1'b0;
      r_scrub <= 1'b0;
      r_addr  <= '0;
    end else if (RST) begin
      r_err   <= 1'b0;
      r_ce    <= 1'b0;
      r_scrub <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_err   <= bus.ERROR;
      r_ce    <= bus.CORRECTABLE;
      r_scrub <= bus.NOW_SCRUBBING;
      r_addr  <= bus.RAM_RA_LAT;
    end
  end

  assign w_ce_ev = r_err & r_ce;
  assign w_ue_ev = r_err & ~r_ce;

  // A clear coinciding with an event leaves the affected counter at 1.
  always_comb begin
    w_ce_cnt_d = r_ce_cnt;
    w_ue_cnt_d = r_ue_cnt;
    if (bus.CNT_CLR) begin
      w_ce_cnt_d = CNT_WIDTH'(w_ce_ev);
      w_ue_cnt_d = CNT_WIDTH'(w_ue_ev);
    end else begin
      if (w_ce_ev && (r_ce_cnt != '1)) w_ce_cnt_d = r_ce_cnt + 1'b1;
      if (w_ue_ev && (r_ue_cnt != '1)) w_ue_cnt_d = r_ue_cnt + 1'b1;
    end
  end

  always_ff @(posedge RCLK or negedge NGRST) begin
    if (!NGRST) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else if (RST) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ce_cnt <= w_ce_cnt_d;
      r_ue_cnt <= w_ue_cnt_d;
      r_ovf    <= r_ovf | w_drop;
      // Set beats clear; only the first drop counts as a new overflow.
      if (w_ue_ev || (w_drop && !r_ovf)) begin
        r_irq <= 1'b1;
      end else if (bus.IRQ_CLR) begin
        r_irq <= 1'b0;
      end
    end
  end

  always_comb begin
    w_entry       = '0;
    w_entry.addr  = LOG_ADDR_MAX_W'(r_addr);
    w_entry.ue    = ~r_ce;
    w_entry.scrub = r_scrub;
  end

  edac_errlog_fifo u_fifo (
    .i_clk   (RCLK),
    .i_rst_n (NGRST),
    .i_clr   (RST),
    .i_push  (r_err),
    .i_entry (w_entry),
    .i_pop   (bus.LOG_POP),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  generate
    if (ADDR_WIDTH < LOG_ADDR_MAX_W) begin : g_addr_pad
      logic w_unused_addr;
      assign w_unused_addr = ^w_head.addr[LOG_ADDR_MAX_W-1:ADDR_WIDTH];
    end
  endgenerate

  assign bus.CE_CNT    = r_ce_cnt;
  assign bus.UE_CNT    = r_ue_cnt;
  assign bus.LOG_VALID = ~w_empty;
  assign bus.LOG_ADDR  = w_empty ? '0 : w_head.addr[ADDR_WIDTH-1:0];
  assign bus.LOG_UE    = ~w_empty & w_head.ue;
  assign bus.LOG_SCRUB = ~w_empty & w_head.scrub;
  assign bus.OVERFLOW  = r_ovf;
  assign bus.IRQ       = r_irq;

endmodule

// File: tb/tb_edac_err_logger.sv
// Bench for edac_err_logger: directed scenarios plus a randomized run against a queue-based
// behavioural model. Works with or without EDAC_ERRLOG_FIFO_EN.
module tb_edac_err_logger;
  import edac_errlog_pkg::*;

  localparam int unsigned AW   = 8;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic RCLK  = 1'b0;
  logic NGRST = 1'b1;
  logic RST   = 1'b0;

  edac_err_logger_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  edac_err_logger #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .RCLK  (RCLK),
    .NGRST (NGRST),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 RCLK = ~RCLK;

  typedef struct {
    logic [7:0] addr;
    bit         ue;
    bit         scrub;
  } ent_t;

  // Reference model: log as a queue, counters as integers, pending = event awaiting its edge.
  ent_t       m_q[$];
  int         m_ce, m_ue;
  bit         m_ovf, m_irq;
  bit         p_err, p_ce, p_scrub;
  logic [7:0] p_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic m_clear();
    m_q.delete();
    m_ce = 0; m_ue = 0; m_ovf = 0; m_irq = 0;
    p_err = 0; p_ce = 0; p_scrub = 0; p_addr = '0;
  endtask

  task automatic m_step();
    bit   ce_ev, ue_ev, drop;
    ent_t e;
    if (RST) begin
      m_clear();
      return;
    end
    ce_ev = p_err && p_ce;
    ue_ev = p_err && !p_ce;
    drop  = 0;
    if (bus.CNT_CLR) begin
      m_ce = ce_ev ? 1 : 0;
      m_ue = ue_ev ? 1 : 0;
    end else begin
      if (ce_ev && m_ce < CMAX) m_ce++;
      if (ue_ev && m_ue < CMAX) m_ue++;
    end
    if (bus.LOG_POP && m_q.size() > 0) void'(m_q.pop_front());
    if (p_err) begin
      if (m_q.size() < LOG_DEPTH) begin
        e.addr = p_addr; e.ue = !p_ce; e.scrub = p_scrub;
        m_q.push_back(e);
      end else begin
        drop = 1;
      end
    end
    if (ue_ev || (drop && !m_ovf)) m_irq = 1;
    else if (bus.IRQ_CLR) m_irq = 0;
    if (drop) m_ovf = 1;
    p_err = bus.ERROR; p_ce = bus.CORRECTABLE; p_scrub = bus.NOW_SCRUBBING;
    p_addr = bus.RAM_RA_LAT;
  endtask

  task automatic clock();
    m_step();
    @(posedge RCLK);
    #1;
  endtask

  task automatic idle();
    bus.ERROR = 0; bus.CORRECTABLE = 0; bus.NOW_SCRUBBING = 0; bus.RAM_RA_LAT = '0;
    bus.CNT_CLR = 0; bus.LOG_POP = 0; bus.IRQ_CLR = 0; RST = 0;
  endtask

  task automatic ev(input bit ce, input bit scrub, input logic [7:0] a);
    bus.ERROR = 1; bus.CORRECTABLE = ce; bus.NOW_SCRUBBING = scrub; bus.RAM_RA_LAT = a;
  endtask

  task automatic sync_clear();
    idle(); RST = 1; clock(); RST = 0;
  endtask

  task automatic test_reset();
    idle();
    m_clear();
    #3 NGRST = 0;
    #2;
    n_tests++; if (bus.CE_CNT !== '0) begin n_fail++; $display("FAIL reset.ce_cnt got %0d exp 0", bus.CE_CNT); end
    n_tests++; if (bus.UE_CNT !== '0) begin n_fail++; $display("FAIL reset.ue_cnt got %0d exp 0", bus.UE_CNT); end
    n_tests++; if (bus.LOG_VALID !== 1'b0) begin n_fail++; $display("FAIL reset.log_valid got %b exp 0", bus.LOG_VALID); end
    n_tests++; if (bus.LOG_ADDR !== '0) begin n_fail++; $display("FAIL reset.log_addr got %h exp 00", bus.LOG_ADDR); end
    n_tests++; if (bus.OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset.overflow got %b exp 0", bus.OVERFLOW); end
    n_tests++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL reset.irq got %b exp 0", bus.IRQ); end
    @(posedge RCLK); #1;
    NGRST = 1;
    clock();
  endtask

  task automatic test_single_ce();
    sync_clear();
    ev(1, 0, 8'h2A);
    clock();
    idle();
    n_tests++; if (bus.CE_CNT !== 4'd0) begin n_fail++; $display("FAIL ce_latency.ce_cnt got %0d exp 0", bus.CE_CNT); end
    clock();
    n_tests++; if (bus.CE_CNT !== 4'd1) begin n_fail++; $display("FAIL single_ce.ce_cnt got %0d exp 1", bus.CE_CNT); end
    n_tests++; if (bus.UE_CNT !== 4'd0) begin n_fail++; $display("FAIL single_ce.ue_cnt got %0d exp 0", bus.UE_CNT); end
    n_tests++; if (bus.LOG_VALID !== 1'b1) begin n_fail++; $display("FAIL single_ce.log_valid got %b exp 1", bus.LOG_VALID); end
    n_tests++; if (bus.LOG_ADDR !== 8'h2A) begin n_fail++; $display("FAIL single_ce.log_addr got %h exp 2a", bus.LOG_ADDR); end
    n_tests++; if (bus.LOG_UE !== 1'b0) begin n_fail++; $display("FAIL single_ce.log_ue got %b exp 0", bus.LOG_UE); end
    n_tests++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL single_ce.irq got %b exp 0", bus.IRQ); end
  endtask

  task automatic test_ue_scrub_irq();
    sync_clear();
    ev(0, 1, 8'h05);
    clock();
    idle();
    clock();
    n_tests++; if (bus.UE_CNT !== 4'd1) begin n_fail++; $display("FAIL ue_scrub.ue_cnt got %0d exp 1", bus.UE_CNT); end
    n_tests++; if (bus.LOG_ADDR !== 8'h05) begin n_fail++; $display("FAIL ue_scrub.log_addr got %h exp 05", bus.LOG_ADDR); end
    n_tests++; if (bus.LOG_UE !== 1'b1) begin n_fail++; $display("FAIL ue_scrub.log_ue got %b exp 1", bus.LOG_UE); end
    n_tests++; if (bus.LOG_SCRUB !== 1'b1) begin n_fail++; $display("FAIL ue_scrub.log_scrub got %b exp 1", bus.LOG_SCRUB); end
    n_tests++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL ue_scrub.irq got %b exp 1", bus.IRQ); end
    bus.IRQ_CLR = 1;
    clock();
    bus.IRQ_CLR = 0;
    n_tests++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_clr.irq got %b exp 0", bus.IRQ); end
    ev(0, 0, 8'h06);
    clock();
    idle();
    bus.IRQ_CLR = 1;
    clock();
    bus.IRQ_CLR = 0;
    n_tests++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins.irq got %b exp 1", bus.IRQ); end
    n_tests++; if (bus.UE_CNT !== 4'd2) begin n_fail++; $display("FAIL irq_set_wins.ue_cnt got %0d exp 2", bus.UE_CNT); end
  endtask

  task automatic test_overflow();
    sync_clear();
    for (int i = 1; i <= int'(LOG_DEPTH) + 1; i++) begin
      ev(1, 0, 8'(i));
      clock();
    end
    idle();
    clock();
    n_tests++; if (bus.OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL overflow.flag got %b exp 1", bus.OVERFLOW); end
    n_tests++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("FAIL overflow.irq got %b exp 1", bus.IRQ); end
    n_tests++; if (bus.CE_CNT !== CW'(LOG_DEPTH + 1)) begin n_fail++; $display("FAIL overflow.ce_cnt got %0d exp %0d", bus.CE_CNT, LOG_DEPTH + 1); end
    for (int i = 1; i <= int'(LOG_DEPTH); i++) begin
      n_tests++; if (bus.LOG_ADDR !== 8'(i)) begin n_fail++; $display("FAIL overflow.pop%0d got %h exp %h", i, bus.LOG_ADDR, 8'(i)); end
      bus.LOG_POP = 1;
      clock();
      bus.LOG_POP = 0;
    end
    n_tests++; if (bus.LOG_VALID !== 1'b0) begin n_fail++; $display("FAIL overflow.drained got %b exp 0", bus.LOG_VALID); end
    n_tests++; if (bus.LOG_ADDR !== 8'h00) begin n_fail++; $display("FAIL overflow.empty_addr got %h exp 00", bus.LOG_ADDR); end
    n_tests++; if (bus.OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL overflow.sticky got %b exp 1", bus.OVERFLOW); end
  endtask

  task automatic test_full_pop_push();
    sync_clear();
    for (int i = 0; i < int'(LOG_DEPTH); i++) begin
      ev(1, 0, (i == 0) ? 8'h10 : 8'(8'h20 + i));
      clock();
    end
    idle();
    clock();
    n_tests++; if (bus.LOG_ADDR !== 8'h10) begin n_fail++; $display("FAIL full_pp.head got %h exp 10", bus.LOG_ADDR); end
    ev(1, 0, 8'h11);
    clock();
    idle();
    bus.LOG_POP = 1;
    clock();
    bus.LOG_POP = 0;
    n_tests++; if (bus.OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL full_pp.overflow got %b exp 0", bus.OVERFLOW); end
    for (int i = 0; i < int'(LOG_DEPTH) - 1; i++) begin
      bus.LOG_POP = 1;
      clock();
      bus.LOG_POP = 0;
    end
    n_tests++; if (bus.LOG_ADDR !== 8'h11) begin n_fail++; $display("FAIL full_pp.tail got %h exp 11", bus.LOG_ADDR); end
    n_tests++; if (bus.LOG_VALID !== 1'b1) begin n_fail++; $display("FAIL full_pp.valid got %b exp 1", bus.LOG_VALID); end
  endtask

  task automatic test_saturation_clear();
    sync_clear();
    for (int i = 0; i < 20; i++) begin
      ev(1, 0, 8'(i));
      clock();
    end
    idle();
    clock();
    n_tests++; if (bus.CE_CNT !== 4'd15) begin n_fail++; $display("FAIL saturate.ce_cnt got %0d exp 15", bus.CE_CNT); end
    ev(1, 0, 8'h33);
    clock();
    idle();
    bus.CNT_CLR = 1;
    clock();
    bus.CNT_CLR = 0;
    n_tests++; if (bus.CE_CNT !== 4'd1) begin n_fail++; $display("FAIL clr_event.ce_cnt got %0d exp 1", bus.CE_CNT); end
    n_tests++; if (bus.UE_CNT !== 4'd0) begin n_fail++; $display("FAIL clr_event.ue_cnt got %0d exp 0", bus.UE_CNT); end
    for (int i = 0; i < 3; i++) begin
      ev(0, 0, 8'(8'h40 + i));
      clock();
    end
    NGRST = 0;
    #2;
    n_tests++; if (bus.CE_CNT !== '0 || bus.UE_CNT !== '0) begin n_fail++; $display("FAIL ngrst.cnts got %0d/%0d exp 0/0", bus.CE_CNT, bus.UE_CNT); end
    n_tests++; if (bus.LOG_VALID !== 1'b0 || bus.LOG_ADDR !== '0) begin n_fail++; $display("FAIL ngrst.log got %b/%h exp 0/00", bus.LOG_VALID, bus.LOG_ADDR); end
    n_tests++; if (bus.OVERFLOW !== 1'b0 || bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL ngrst.flags got %b/%b exp 0/0", bus.OVERFLOW, bus.IRQ); end
    m_clear();
    idle();
    NGRST = 1;
    clock();
    n_tests++; if (bus.UE_CNT !== 4'd0) begin n_fail++; $display("FAIL ngrst.inflight got %0d exp 0", bus.UE_CNT); end
  endtask

  task automatic test_rst_discard();
    sync_clear();
    ev(1, 0, 8'h55);
    clock();
    idle();
    RST = 1;
    clock();
    RST = 0;
    clock();
    n_tests++; if (bus.CE_CNT !== 4'd0) begin n_fail++; $display("FAIL rst_inreg.ce_cnt got %0d exp 0", bus.CE_CNT); end
    n_tests++; if (bus.LOG_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_inreg.valid got %b exp 0", bus.LOG_VALID); end
    ev(0, 0, 8'h66);
    RST = 1;
    clock();
    idle();
    clock();
    n_tests++; if (bus.UE_CNT !== 4'd0) begin n_fail++; $display("FAIL rst_sampled.ue_cnt got %0d exp 0", bus.UE_CNT); end
    n_tests++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_sampled.irq got %b exp 0", bus.IRQ); end
  endtask

  task automatic test_random();
    logic [7:0] e_addr;
    bit         e_valid, e_ue, e_scrub;
    sync_clear();
    for (int c = 0; c < 800; c++) begin
      bus.ERROR         = ($urandom_range(0, 2) != 0);
      bus.CORRECTABLE   = $urandom_range(0, 1);
      bus.NOW_SCRUBBING = $urandom_range(0, 1);
      bus.RAM_RA_LAT    = 8'($urandom);
      bus.CNT_CLR       = ($urandom_range(0, 15) == 0);
      bus.LOG_POP       = ($urandom_range(0, 2) == 0);
      bus.IRQ_CLR       = ($urandom_range(0, 5) == 0);
      RST               = ($urandom_range(0, 63) == 0);
      clock();
      e_valid = (m_q.size() > 0);
      e_addr  = e_valid ? m_q[0].addr : 8'h00;
      e_ue    = e_valid ? m_q[0].ue : 1'b0;
      e_scrub = e_valid ? m_q[0].scrub : 1'b0;
      n_tests++; if (bus.CE_CNT !== CW'(m_ce)) begin n_fail++; $display("FAIL rand.ce_cnt cyc %0d got %0d exp %0d", c, bus.CE_CNT, m_ce); end
      n_tests++; if (bus.UE_CNT !== CW'(m_ue)) begin n_fail++; $display("FAIL rand.ue_cnt cyc %0d got %0d exp %0d", c, bus.UE_CNT, m_ue); end
      n_tests++; if (bus.LOG_VALID !== e_valid) begin n_fail++; $display("FAIL rand.log_valid cyc %0d got %b exp %b", c, bus.LOG_VALID, e_valid); end
      n_tests++; if (bus.LOG_ADDR !== e_addr) begin n_fail++; $display("FAIL rand.log_addr cyc %0d got %h exp %h", c, bus.LOG_ADDR, e_addr); end
      n_tests++; if (bus.LOG_UE !== e_ue) begin n_fail++; $display("FAIL rand.log_ue cyc %0d got %b exp %b", c, bus.LOG_UE, e_ue); end
      n_tests++; if (bus.LOG_SCRUB !== e_scrub) begin n_fail++; $display("FAIL rand.log_scrub cyc %0d got %b exp %b", c, bus.LOG_SCRUB, e_scrub); end
      n_tests++; if (bus.OVERFLOW !== m_ovf) begin n_fail++; $display("FAIL rand.overflow cyc %0d got %b exp %b", c, bus.OVERFLOW, m_ovf); end
      n_tests++; if (bus.IRQ !== m_irq) begin n_fail++; $display("FAIL rand.irq cyc %0d got %b exp %b", c, bus.IRQ, m_irq); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_ce();
    test_ue_scrub_irq();
    test_overflow();
    test_full_pop_push();
    test_saturation_clear();
    test_rst_discard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
